cmp_pipe: RTL and testbench
===========================

CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be even and >= 4.
REQ-002 Parameter CNT_W, default 8, width of the true-result counter.
REQ-003 CLK  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 RESETN  input  1  reset, asynchronous, active-low.
REQ-005 I0  input  WIDTH  first operand.
REQ-006 I1  input  WIDTH  second operand.
REQ-007 OP  input  3  compare operation, encoded per REQ-012.
REQ-008 I_VALID / I_READY  input / output  1 each  input handshake.
REQ-009 O / O_VALID / O_READY  output / output / input  1 each  result and output handshake.
REQ-010 CLR  input  1  synchronous clear of CNT.
REQ-011 CNT  output  CNT_W  saturating count of delivered results equal to 1.

Function
REQ-012 OP encoding SHALL be: 0 EQ, 1 NE, 2 LT signed, 3 GE signed, 4 LTU, 5 GEU, 6 LE signed, 7 GT signed.
REQ-013 Difference D SHALL be I0 + ~I1 + 1, with carry-out C; Z = (D==0); N = D[WIDTH-1]; V = (I0 msb != I1 msb) and (N != I0 msb).
REQ-014 LT SHALL be N xor V; LTU SHALL be not C; LE SHALL be LT or Z; GT SHALL be not LE; GE/GEU/NE SHALL be the inversions of LT/LTU/EQ; EQ SHALL be Z.
REQ-015 Stage A SHALL compute the low WIDTH/2 bits of D. It SHALL register the low carry, the low-zero flag, the upper operand halves, OP and a valid bit.
REQ-016 Stage B SHALL complete the upper half from the registered carry, form the flags, select the result per OP, and register O.
REQ-017 Latency SHALL be exactly 2 cycles from an accepted input (I_VALID and I_READY) to O_VALID when O_READY is held high.
REQ-018 Throughput SHALL be one result per cycle when O_READY is high.
REQ-019 Stage B SHALL load when it is empty or O_READY=1.
REQ-020 Stage A SHALL transfer to B under the same condition.
REQ-021 I_READY SHALL be (stage A empty) or (stage A transferring this cycle); it is combinational from O_READY.
REQ-022 O, O_VALID and stage contents SHALL hold stable while O_VALID=1 and O_READY=0.
REQ-023 No result SHALL be dropped or duplicated, and results SHALL leave in acceptance order.
REQ-024 CNT SHALL increment by 1 on each output handshake with O=1 and saturate at all-ones.
REQ-025 If CLR and an increment coincide, CLR SHALL win and CNT SHALL become 0.

Reset
REQ-026 On RESETN low, both stage valid bits, O, O_VALID and CNT SHALL clear to 0 immediately, and I_READY SHALL read 1.
REQ-027 In-flight operands at reset SHALL be discarded.
REQ-028 The first accepted input after RESETN rises SHALL produce its result with the normal 2-cycle latency.

Structure
REQ-029 The OP encodings and the flag-to-result mapping constants SHALL live in shared package cmp_pkg.
REQ-030 Both half-width adds SHALL instantiate one sub-module, sub_slice: a WIDTH/2-bit ripple add of I0 + ~I1 with carry-in and carry-out, and a zero flag.
REQ-031 Stage A's sub_slice SHALL take carry-in 1; stage B's SHALL take the registered carry.

Verification (WIDTH=16 unless stated)
REQ-032 I0=0x8000, I1=0x0001: OP=LT -> O=1; OP=LTU -> O=0; each after 2 cycles.
REQ-033 I0=0x7FFF, I1=0xFFFF: OP=GT -> O=1 (V=1 path); OP=GEU -> O=0.
REQ-034 I0=0x0100, I1=0x00FF (borrow crosses halves): OP=LTU -> 0; GEU -> 1; EQ -> 0; then I0=I1=0x1234, OP=EQ -> 1.
REQ-035 O_READY held low, five back-to-back inputs offered:
- I_READY SHALL drop after 2 accepted.
- On release, all five results SHALL emerge in order with none lost.
REQ-036 CNT_W=2, six true results delivered -> CNT SHALL reach 3 and hold; CLR coinciding with a true handshake -> CNT=0.
REQ-037 RESETN pulsed low while both stages are valid:
- O_VALID=0 and CNT=0 SHALL hold immediately.
- No stale result SHALL appear afterwards.

Source files
------------

// File: rtl/cmp_pipe_pkg.sv
// Shared compare definitions: operation encodings and flag-to-result mapping.
package cmp_pkg;

  typedef enum logic [2:0] {
    OP_EQ  = 3'd0,
    OP_NE  = 3'd1,
    OP_LT  = 3'd2,
    OP_GE  = 3'd3,
    OP_LTU = 3'd4,
    OP_GEU = 3'd5,
    OP_LE  = 3'd6,
    OP_GT  = 3'd7
  } cmp_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic v;
    logic c;
  } flags_t;

  // Opcodes come in base/inverted pairs: op[2:1] picks the base relation,
  // op[0] inverts it (NE, GE, GEU, GT).
  localparam logic [1:0] BASE_EQ  = 2'd0;
  localparam logic [1:0] BASE_LT  = 2'd1;
  localparam logic [1:0] BASE_LTU = 2'd2;
  localparam logic [1:0] BASE_LE  = 2'd3;

  function automatic logic cmp_result(input cmp_op_e op, input flags_t f);
    logic [2:0] code;
    logic       lt;
    logic       base;
    code = op;
    lt   = f.n ^ f.v;
    base = 1'b0;
    case (code[2:1])
      BASE_EQ:  base = f.z;
      BASE_LT:  base = lt;
      BASE_LTU: base = ~f.c;
      BASE_LE:  base = lt | f.z;
    endcase
    return base ^ code[0];
  endfunction

endpackage

// File: rtl/cmp_pipe_if.sv
// Operand/result handshake bundle for cmp_pipe.
interface cmp_pipe_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
);
  logic [WIDTH-1:0] I0;
  logic [WIDTH-1:0] I1;
  logic [2:0]       OP;
  logic             I_VALID;
  logic             I_READY;
  logic             O;
  logic             O_VALID;
  logic             O_READY;
  logic             CLR;
  logic [CNT_W-1:0] CNT;

  modport master (
    output I0, I1, OP, I_VALID, O_READY, CLR,
    input  I_READY, O, O_VALID, CNT
  );

  modport slave (
    input  I0, I1, OP, I_VALID, O_READY, CLR,
    output I_READY, O, O_VALID, CNT
  );
endinterface

// File: rtl/cmp_pipe_sub_slice.sv
// Half-width ripple subtract slice: a + ~b + cin, with carry-out and zero flag.
module sub_slice #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         zero_o
);

  logic carry;

  // Bit-serial ripple through the slice.
  always_comb begin
    carry = cin_i;
    sum_o = '0;
    for (int unsigned k = 0; k < W; k++) begin
      sum_o[k] = a_i[k] ^ ~b_i[k] ^ carry;
      carry    = (a_i[k] & ~b_i[k]) | (carry & (a_i[k] ^ ~b_i[k]));
    end
    cout_o = carry;
  end

  assign zero_o = ~|sum_o;

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage pipelined comparator with valid/ready handshake and a
// saturating count of delivered true results.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 8
) (
  input logic     CLK,
  input logic     RESETN,
  cmp_pipe_if.slave bus
);

  localparam int unsigned H = WIDTH / 2;

  logic [H-1:0]     unused_lo_sum;
  logic [H-2:0]     unused_hi_bits;
  logic             lo_c, lo_z;
  logic [H-1:0]     hi_sum;
  logic             hi_c, hi_z;
  flags_t           flags;
  logic             res;
  logic             b_load, a_ready;

  logic             a_vld_q, a_vld_d;
  logic             a_c_q, a_c_d;
  logic             a_z_q, a_z_d;
  logic [H-1:0]     a_hi0_q, a_hi0_d;
  logic [H-1:0]     a_hi1_q, a_hi1_d;
  cmp_op_e          a_op_q, a_op_d;
  logic             b_vld_q, b_vld_d;
  logic             o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sub_slice #(.W(H)) u_lo (
    .a_i    (bus.I0[H-1:0]),
    .b_i    (bus.I1[H-1:0]),
    .cin_i  (1'b1),
    .sum_o  (unused_lo_sum),
    .cout_o (lo_c),
    .zero_o (lo_z)
  );

  sub_slice #(.W(H)) u_hi (
    .a_i    (a_hi0_q),
    .b_i    (a_hi1_q),
    .cin_i  (a_c_q),
    .sum_o  (hi_sum),
    .cout_o (hi_c),
    .zero_o (hi_z)
  );

  assign unused_hi_bits = hi_sum[H-2:0];

  // Stage B flag formation and result selection.
  always_comb begin
    flags.z = a_z_q & hi_z;
    flags.n = hi_sum[H-1];
    flags.c = hi_c;
    flags.v = (a_hi0_q[H-1] ^ a_hi1_q[H-1]) & (flags.n ^ a_hi0_q[H-1]);
    res     = cmp_result(a_op_q, flags);
  end

  // Pipeline advance, stage loads and counter next-state.
  always_comb begin
    b_load  = ~b_vld_q | bus.O_READY;
    a_ready = ~a_vld_q | b_load;

    a_vld_d = a_vld_q;
    a_c_d   = a_c_q;
    a_z_d   = a_z_q;
    a_hi0_d = a_hi0_q;
    a_hi1_d = a_hi1_q;
    a_op_d  = a_op_q;
    b_vld_d = b_vld_q;
    o_d     = o_q;
    cnt_d   = cnt_q;

    if (a_ready) begin
      a_vld_d = bus.I_VALID;
      a_c_d   = lo_c;
      a_z_d   = lo_z;
      a_hi0_d = bus.I0[WIDTH-1:H];
      a_hi1_d = bus.I1[WIDTH-1:H];
      a_op_d  = cmp_op_e'(bus.OP);
    end

    if (b_load) begin
      b_vld_d = a_vld_q;
      o_d     = a_vld_q & res;
    end

    if (bus.CLR) begin
      cnt_d = '0;
    end else if (b_vld_q && bus.O_READY && o_q && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset empties both stages and the counter.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      a_vld_q <= 1'b0;
      a_c_q   <= 1'b0;
      a_z_q   <= 1'b0;
      a_hi0_q <= '0;
      a_hi1_q <= '0;
      a_op_q  <= OP_EQ;
      b_vld_q <= 1'b0;
      o_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_vld_q <= a_vld_d;
      a_c_q   <= a_c_d;
      a_z_q   <= a_z_d;
      a_hi0_q <= a_hi0_d;
      a_hi1_q <= a_hi1_d;
      a_op_q  <= a_op_d;
      b_vld_q <= b_vld_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.I_READY = a_ready;
  assign bus.O       = o_q;
  assign bus.O_VALID = b_vld_q;
  assign bus.CNT     = cnt_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: directed corner cases, backpressure,
// randomized traffic against a scoreboard, counter saturation and reset.
module tb_cmp_pipe;

  logic CLK = 1'b0;
  logic RESETN;
  always #5 CLK = ~CLK;

  cmp_pipe_if #(.WIDTH(16), .CNT_W(8)) bus ();
  cmp_pipe_if #(.WIDTH(16), .CNT_W(2)) bus2 ();

  cmp_pipe #(.WIDTH(16), .CNT_W(8)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  cmp_pipe #(.WIDTH(16), .CNT_W(2)) dut2 (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus2)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit exp_q[$];
  int cnt_model  = 0;
  logic [15:0] edges [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

  function automatic logic ref_cmp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return $signed(a) <  $signed(b);
      3'd3: return $signed(a) >= $signed(b);
      3'd4: return a <  b;
      3'd5: return a >= b;
      3'd6: return $signed(a) <= $signed(b);
      default: return $signed(a) > $signed(b);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshakes into the scoreboard, then check after the edge.
  task automatic tick();
    logic hold_v, hold_o, e;
    #1;
    if (bus.I_VALID && bus.I_READY) exp_q.push_back(ref_cmp(bus.OP, bus.I0, bus.I1));
    hold_v = bus.O_VALID && !bus.O_READY;
    hold_o = bus.O;
    if (bus.O_VALID && bus.O_READY) begin
      chk("out_has_pending", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", bus.O, e);
        if (e && cnt_model < 255) cnt_model++;
      end
    end
    if (bus.CLR) cnt_model = 0;
    @(posedge CLK);
    @(negedge CLK);
    chk("cnt", bus.CNT, cnt_model);
    if (hold_v) begin
      chk("hold_valid", bus.O_VALID, 1);
      chk("hold_o", bus.O, hold_o);
    end
  endtask

  task automatic send_one(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic exp_o);
    bus.I0 = a; bus.I1 = b; bus.OP = op;
    bus.I_VALID = 1'b1; bus.O_READY = 1'b1; bus.CLR = 1'b0;
    tick();
    bus.I_VALID = 1'b0;
    chk({tag, "_lat1"}, bus.O_VALID, 0);
    tick();
    chk({tag, "_lat2"}, bus.O_VALID, 1);
    chk(tag, bus.O, exp_o);
    tick();
  endtask

  task automatic drain();
    bus.I_VALID = 1'b0; bus.O_READY = 1'b1; bus.CLR = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int idx, n2;
    logic acc;
    logic [15:0] ia [5];
    logic [15:0] ib [5];
    logic [15:0] a, b;

    RESETN = 1'b0;
    bus.I0 = '0; bus.I1 = '0; bus.OP = '0; bus.I_VALID = 1'b0; bus.O_READY = 1'b0; bus.CLR = 1'b0;
    bus2.I0 = '0; bus2.I1 = '0; bus2.OP = '0; bus2.I_VALID = 1'b0; bus2.O_READY = 1'b0; bus2.CLR = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_ovalid", bus.O_VALID, 0);
    chk("rst_o", bus.O, 0);
    chk("rst_cnt", bus.CNT, 0);
    chk("rst_iready", bus.I_READY, 1);
    chk("rst_cnt2", bus2.CNT, 0);
    RESETN = 1'b1;
    @(negedge CLK);

    // Directed corner cases.
    send_one("lt_8000_0001",  16'h8000, 16'h0001, 3'd2, 1'b1);
    send_one("ltu_8000_0001", 16'h8000, 16'h0001, 3'd4, 1'b0);
    send_one("gt_7fff_ffff",  16'h7FFF, 16'hFFFF, 3'd7, 1'b1);
    send_one("geu_7fff_ffff", 16'h7FFF, 16'hFFFF, 3'd5, 1'b0);
    send_one("ltu_0100_00ff", 16'h0100, 16'h00FF, 3'd4, 1'b0);
    send_one("geu_0100_00ff", 16'h0100, 16'h00FF, 3'd5, 1'b1);
    send_one("eq_0100_00ff",  16'h0100, 16'h00FF, 3'd0, 1'b0);
    send_one("eq_1234_1234",  16'h1234, 16'h1234, 3'd0, 1'b1);
    send_one("le_equal",      16'hFFFE, 16'hFFFE, 3'd6, 1'b1);
    send_one("ne_low_equal",  16'h1200, 16'h3400, 3'd1, 1'b1);

    // Five back-to-back inputs against a stalled output.
    for (int i = 0; i < 5; i++) begin
      ia[i] = 16'($urandom);
      ib[i] = 16'($urandom);
    end
    idx = 0;
    bus.CLR = 1'b0;
    for (int c = 0; c < 40 && idx < 5; c++) begin
      bus.I0 = ia[idx]; bus.I1 = ib[idx]; bus.OP = 3'(idx + 2);
      bus.I_VALID = 1'b1;
      bus.O_READY = (c >= 6);
      #1;
      acc = bus.I_READY;
      if (c == 4) begin
        chk("bp_accepted", idx, 2);
        chk("bp_iready_low", bus.I_READY, 0);
        chk("bp_ovalid", bus.O_VALID, 1);
      end
      tick();
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 5);
    drain();

    // Randomized traffic with random backpressure and clears.
    for (int i = 0; i < 400; i++) begin
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0: b = 16'($urandom);
        1: b = a;
        2: begin a = edges[$urandom_range(0, 3)]; b = edges[$urandom_range(0, 3)]; end
        default: b = a + 16'($urandom_range(0, 2)) - 16'd1;
      endcase
      bus.I0 = a; bus.I1 = b; bus.OP = 3'($urandom_range(0, 7));
      bus.I_VALID = ($urandom_range(0, 3) != 0);
      bus.O_READY = ($urandom_range(0, 3) != 0);
      bus.CLR     = ($urandom_range(0, 31) == 0);
      tick();
    end
    drain();

    // Counter saturation and clear priority on the narrow-counter instance.
    bus2.I0 = 16'h00AA; bus2.I1 = 16'h00AA; bus2.OP = 3'd0;
    bus2.I_VALID = 1'b1; bus2.O_READY = 1'b1; bus2.CLR = 1'b0;
    n2 = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (bus2.O_VALID && bus2.O_READY) begin
        chk("cnt2_o_true", bus2.O, 1);
        n2++;
      end
      @(posedge CLK);
      @(negedge CLK);
      chk("cnt2_sat", bus2.CNT, (n2 > 3) ? 3 : n2);
    end
    bus2.CLR = 1'b1;
    #1;
    chk("cnt2_clr_hs", (bus2.O_VALID && bus2.O_READY && bus2.O), 1);
    @(posedge CLK);
    @(negedge CLK);
    chk("cnt2_clr_wins", bus2.CNT, 0);
    bus2.CLR = 1'b0;
    bus2.I_VALID = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset with both stages full.
    bus.I0 = 16'h0005; bus.I1 = 16'h0005; bus.OP = 3'd0;
    bus.I_VALID = 1'b1; bus.O_READY = 1'b0; bus.CLR = 1'b0;
    tick();
    tick();
    chk("pre_rst_full", bus.O_VALID, 1);
    bus.I_VALID = 1'b0;
    #2;
    RESETN = 1'b0;
    #1;
    chk("rst_async_ovalid", bus.O_VALID, 0);
    chk("rst_async_cnt", bus.CNT, 0);
    chk("rst_async_iready", bus.I_READY, 1);
    exp_q.delete();
    cnt_model = 0;
    @(negedge CLK);
    RESETN = 1'b1;
    bus.O_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("no_stale_out", bus.O_VALID, 0);
    end
    send_one("post_rst_gt", 16'h0003, 16'hFFFD, 3'd7, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
